pingpong_input_buffer: RTL

Parametrised, double-buffered input frame store for the neural-network input module. A sequential loader streams one frame (e.g. one 28×28 image) into one bank while the compute side randomly reads the previously completed frame from the other bank. Banks swap under a full/release handshake, so loading and inference overlap without corrupting the frame in use.

---
 rtl/input_buf_pkg.sv | 20 ++
 rtl/sdp_bram_bank.sv | 45 ++++
 rtl/pingpong_input_buffer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/input_buf_pkg.sv
// Shared definitions for the neural-network input frame store.
//
// Contents:
//   MNIST_FRAME_DEPTH - words in one 28x28 input image
//   DEFAULT_DATA_W    - default word width of the loader/compute interface
//   bank_sel_t        - selects one of the two ping-pong banks
//   addr_width()      - bank address width for a given depth (never below 1)
package input_buf_pkg;

  localparam int MNIST_FRAME_DEPTH = 784;
  localparam int DEFAULT_DATA_W    = 8;

  typedef logic bank_sel_t;

  // A depth of 1 would give $clog2()==0, which cannot size a vector.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sdp_bram_bank.sv
// One bank of the ping-pong frame store: simple dual-port RAM with a
// synchronous write port and a registered read port, written so that
// synthesis maps it onto block RAM. The array has no reset.
//
// Ports:
//   clk     - clock
//   wr_en   - write wr_data at wr_addr on the next rising edge
//   wr_addr - write address
//   wr_data - write data
//   rd_en   - load rd_data from rd_addr on the next rising edge
//   rd_addr - read address
//   rd_data - registered read data; holds while rd_en is low
module sdp_bram_bank
  import input_buf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = MNIST_FRAME_DEPTH
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [addr_width(DEPTH)-1:0]  wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  input  logic [addr_width(DEPTH)-1:0]  rd_addr,
  output logic [DATA_W-1:0]             rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port. Callers only ever present addresses below DEPTH.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; the output register keeps its value between
  // reads, which the top level relies on to hold rd_data.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pingpong_input_buffer.sv
// Double-buffered input frame store. A sequential loader fills one bank
// while the compute side randomly reads the previously completed frame
// from the other bank; banks change hands through a full/release handshake.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   wr_valid      - loader presents a word on wr_data
//   wr_ready      - buffer accepts a word this cycle
//   wr_data       - loader word, stored at the next sequential address
//   wr_flush      - drop the partially loaded frame
//   rd_en         - read request from the compute side
//   rd_addr       - word address inside the current read frame
//   rd_data       - read data, one cycle after the request
//   rd_valid      - rd_data carries the result of an accepted read
//   frame_valid   - a complete frame is available for reading
//   rd_release    - consumer is done with the current frame
//   frames_stored - number of full banks (0..2)
module pingpong_input_buffer
  import input_buf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = MNIST_FRAME_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_flush,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              frame_valid,
  input  logic              rd_release,
  output logic [1:0]        frames_stored
);

  localparam int BANK_AW = addr_width(DEPTH);
  localparam logic [BANK_AW-1:0] LAST_PTR = BANK_AW'(DEPTH - 1);
  // One extra bit so DEPTH itself is representable even when it is a power of two.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [1:0]         full;
  logic [1:0]         full_next;
  bank_sel_t          wr_sel;
  bank_sel_t          rd_sel;
  logic [BANK_AW-1:0] wr_ptr;

  logic wr_accept;
  logic wr_last;
  logic rd_accept;
  logic rd_in_range;
  logic rel_accept;

  // Read-side output state: which bank's output register to show, and
  // whether the shown value must be forced to zero (after reset or after
  // an out-of-range read).
  bank_sel_t rd_bank_q;
  logic      rd_zero_q;

  logic [DATA_W-1:0] bank_dout [2];

  assign wr_ready      = !full[wr_sel] && !wr_flush;
  assign wr_accept     = wr_valid && wr_ready;
  assign wr_last       = (wr_ptr == LAST_PTR);
  assign frame_valid   = full[rd_sel];
  assign frames_stored = 2'(full[0]) + 2'(full[1]);
  assign rd_accept     = rd_en && frame_valid;
  assign rd_in_range   = ({1'b0, rd_addr} < DEPTH_EXT);
  assign rel_accept    = rd_release && frame_valid;

  // A release and a bank completion in the same cycle always target
  // different banks (release needs its bank full, completion needs its
  // bank empty), so both updates can be applied independently.
  always_comb begin
    full_next = full;
    if (rel_accept) begin
      full_next[rd_sel] = 1'b0;
    end
    if (wr_accept && wr_last) begin
      full_next[wr_sel] = 1'b1;
    end
  end

  // Bank ownership and write pointer. Flush wins over a simultaneous write
  // because wr_ready is already low while flushing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_ptr <= '0;
    end else begin
      full <= full_next;
      if (rel_accept) begin
        rd_sel <= ~rd_sel;
      end
      if (wr_flush) begin
        wr_ptr <= '0;
      end else if (wr_accept) begin
        if (wr_last) begin
          wr_ptr <= '0;
          wr_sel <= ~wr_sel;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

  // Read response bookkeeping. The read uses rd_sel before any release in
  // the same cycle takes effect, so a read+release returns old-frame data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      rd_zero_q <= 1'b1;
      rd_bank_q <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_zero_q <= !rd_in_range;
        rd_bank_q <= rd_sel;
      end
    end
  end

  // The bank output registers only move on accepted in-range reads, so
  // rd_data holds between requests without a separate data register.
  assign rd_data = rd_zero_q ? '0 : bank_dout[rd_bank_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sdp_bram_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_accept && (wr_sel == 1'(b))),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_en   (rd_accept && rd_in_range && (rd_sel == 1'(b))),
      .rd_addr (rd_addr[BANK_AW-1:0]),
      .rd_data (bank_dout[b])
    );
  end

endmodule
